dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Data-cache responder on the far end of the memory stage's memRead/memWrite/hit interface. Serves 16-bit word loads and stores from an internal direct-mapped, write-back, write-allocate array.
- Reports a same-cycle hit to the pipeline.
- On a miss it stalls the requester, writes back a dirty victim line, refills the line one word at a time from main memory, then replays the request as a hit.

Parameters:
- INDEX_BITS, 5, line index width; LINES = 2^INDEX_BITS = 32 lines.
- WORDS_PER_LINE, 4, fixed; offset = addr[2:1].
- TAG_BITS, 8, = 16 - INDEX_BITS - 3; tag = addr[15:8] at defaults.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- addr  in  16  byte address of request; bit 0 must be 0
- wdata  in  16  store data
- mem_read  in  1  load request
- mem_write  in  1  store request
- rdata  out  16  load data, valid when hit=1 and mem_read=1
- hit  out  1  request completes this cycle
- stall  out  1  = (mem_read|mem_write) & ~hit & ~err
- err  out  1  illegal request or protocol violation
- m_addr  out  16  backing-memory word address
- m_wdata  out  16  backing-memory write data
- m_rd  out  1  backing-memory read request, held until m_ack
- m_wr  out  1  backing-memory write request, held until m_ack
- m_rdata  in  16  backing-memory read data, valid with m_ack
- m_ack  in  1  backing-memory completes the current word this cycle

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all valid and dirty bits cleared, word count=0, saved address=0. rdata, hit, stall, err, m_rd, m_wr, m_addr and m_wdata are all 0. The data and tag arrays are not reset.
- States:
  - IDLE: accepts requests.
  - WB: writes back the dirty victim.
  - FILL: refills the line.
- IDLE lookup is combinational on addr: hit = valid[idx] & (tag[idx]==addr tag) & (mem_read^mem_write) & ~addr[0].
  - rdata = data[idx][off] in the same cycle. Zero latency on a hit.
  - Store hit: the word is written at the clock edge and dirty[idx] is set.
  - No request (both low): hit=0, stall=0, no state change.
- IDLE miss: stall=1 and addr is saved at the clock edge.
  - If valid[idx] & dirty[idx], go to WB; otherwise go to FILL.
  - Word count is cleared on entry.
- WB: m_wr=1, m_addr={victim tag, idx, cnt, 1'b0}, m_wdata=data[idx][cnt].
  - On m_ack, cnt increments.
  - On the ack for cnt=3: cnt=0, dirty[idx] is cleared, go to FILL.
- FILL: m_rd=1, m_addr={saved tag, idx, cnt, 1'b0}.
  - On m_ack, data[idx][cnt] <= m_rdata and cnt increments.
  - On the ack for cnt=3: tag[idx] is written, valid[idx]=1, dirty[idx]=0, go to IDLE.
  - The held request then hits in the next cycle (replay). Miss latency = 1 + (4 or 8 acked words) cycles minimum.
- While in WB or FILL:
  - hit=0 and stall=1.
  - m_addr and m_wdata stay stable until m_ack.
  - m_ack while m_rd=m_wr=0 is ignored.
- The requester must hold addr, wdata, mem_read and mem_write constant while stall=1.
- err conditions (combinational):
  - mem_read & mem_write, in any state;
  - addr[0]=1 with a request present, in IDLE;
  - in WB/FILL, addr differs from the saved address, or the request is dropped.
- With err=1 in IDLE: no array update, no state change, hit=0, stall=0.
- An err raised in WB/FILL does not abort the line transfer.
- m_rd and m_wr are never both 1. Both are 0 in IDLE.
- Reset asserted mid-WB or mid-FILL:
  - m_rd and m_wr drop immediately;
  - the partially filled line stays invalid;
  - a partially written-back victim is lost. Accepted, since reset reinitialises the system.
- Counter wrap: cnt is 2 bits; the transition on cnt=3 takes priority over the increment.

Test Plan:
- Cold load addr=0x1234 after reset, memory returns 0xA0..0xA3 for words 0x1230..0x1236 (ack every cycle) → stall=1 for 5 cycles, 4 m_rd words at 0x1230,0x1232,0x1234,0x1236, then hit=1 with rdata=0xA2; no m_wr at any point.
- Store 0xBEEF to 0x1236, then load 0x1236 → both requests hit=1 with no stall; load returns 0xBEEF; no memory traffic.
- Load 0x3234 (same index 0x06 as 0x1234, different tag) after the dirty store → 4 m_wr words at 0x1230..0x1236, the word at 0x1236 written as 0xBEEF, then 4 m_rd words from 0x3230, then hit.
- Fill with m_ack delayed 3 cycles per word → m_rd and m_addr held stable through each wait; hit asserts only after the 4th ack.
- mem_read=mem_write=1, and separately a load from 0x1235 → err=1, stall=0, hit=0, no state or array change.
- rst=0 pulsed during the 2nd FILL word → m_rd=0 immediately; the next load to that line misses and refills all 4 words.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate 16-bit data cache responder
// clk, rst (async, active-low); request side addr/wdata/mem_read/mem_write -> rdata/hit/stall/err
// backing memory side m_addr/m_wdata/m_rd/m_wr -> m_rdata/m_ack, one word per acknowledged cycle
module dcache_ctrl #(
  parameter int INDEX_BITS     = 5,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_BITS       = 16 - INDEX_BITS - 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [15:0] rdata,
  output logic        hit,
  output logic        stall,
  output logic        err,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [15:0] m_rdata,
  input  logic        m_ack
);
  localparam int LINES = 1 << INDEX_BITS;
  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
  state_t                state;
  logic [15:0]           data [LINES*WORDS_PER_LINE];
  logic [TAG_BITS-1:0]   tags [LINES];
  logic [LINES-1:0]      valid, dirty;
  logic [1:0]            cnt;
  logic [15:0]           saved;
  logic [INDEX_BITS-1:0] idx, s_idx;
  logic [TAG_BITS-1:0]   tag, s_tag;
  logic [1:0]            off;
  logic                  req, ack, last, miss, idle;
  assign idx   = addr[INDEX_BITS+2:3];
  assign off   = addr[2:1];
  assign tag   = addr[15:INDEX_BITS+3];
  assign s_idx = saved[INDEX_BITS+2:3];
  assign s_tag = saved[15:INDEX_BITS+3];
  assign idle  = state == IDLE;
  assign req   = mem_read | mem_write;
  // request-side outputs are gated by rst so they read 0 while reset is held
  assign hit   = rst & idle & valid[idx] & (tags[idx] == tag) & (mem_read ^ mem_write) & ~addr[0];
  assign err   = rst & ((mem_read & mem_write) | (idle ? req & addr[0] : (addr != saved) | ~req));
  assign stall = rst & req & ~hit & ~err;
  assign rdata = hit & mem_read ? data[{idx, off}] : '0;
  assign miss  = idle & stall;
  // memory-side outputs decode the registered state, so reset drops them at once
  assign m_wr    = state == WB;
  assign m_rd    = state == FILL;
  assign m_addr  = m_wr ? {tags[s_idx], s_idx, cnt, 1'b0} : m_rd ? {s_tag, s_idx, cnt, 1'b0} : '0;
  assign m_wdata = m_wr ? data[{s_idx, cnt}] : '0;
  assign ack     = m_ack & (m_rd | m_wr);
  assign last    = ack & (cnt == 2'd3);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      cnt   <= '0;
      saved <= '0;
    end else begin
      case (state)
        IDLE:
          if (hit & mem_write) dirty[idx] <= 1'b1;
          else if (miss) begin
            saved <= addr;
            cnt   <= '0;
            state <= valid[idx] & dirty[idx] ? WB : FILL;
          end
        WB:
          if (ack) begin
            cnt <= last ? 2'd0 : cnt + 2'd1;
            if (last) begin
              dirty[s_idx] <= 1'b0;
              state        <= FILL;
            end
          end
        FILL:
          if (ack) begin
            cnt <= last ? 2'd0 : cnt + 2'd1;
            if (last) begin
              valid[s_idx] <= 1'b1;
              dirty[s_idx] <= 1'b0;
              state        <= IDLE;
            end
          end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk) begin
    if (hit & mem_write) data[{idx, off}] <= wdata;
    if (m_rd & ack) data[{s_idx, cnt}] <= m_rdata;
    if (m_rd & last) tags[s_idx] <= s_tag;
  end
endmodule
